gnn_result_collector: RTL and testbench

Captures the eight layer-2 results of the GNN datapath (two outputs for each of four nodes) once every ready flag is high, and holds them in an internal frame buffer. It then streams the frame out one word per beat over a valid/ready interface. It sits directly downstream of the GNN top level and is the consumer end of its per-node `outX_ready_nodeN` flags, so the datapath never has to hold its outputs stable while a host drains them.

---
 rtl/gnn_result_collector.sv | 143 ++++++++++++++
 tb/tb_gnn_result_collector.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gnn_result_collector.sv
// Captures the eight layer-2 GNN results on a rising edge of the combined ready flags and
// streams them out one word per beat. Optional macro GNN_ARGMAX_EN appends a class-vector word.
module gnn_result_collector #(
    parameter int unsigned OUTPUT_SIZE = 21
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [OUTPUT_SIZE-1:0] out0_node0,
    input  logic [OUTPUT_SIZE-1:0] out0_node1,
    input  logic [OUTPUT_SIZE-1:0] out0_node2,
    input  logic [OUTPUT_SIZE-1:0] out0_node3,
    input  logic [OUTPUT_SIZE-1:0] out1_node0,
    input  logic [OUTPUT_SIZE-1:0] out1_node1,
    input  logic [OUTPUT_SIZE-1:0] out1_node2,
    input  logic [OUTPUT_SIZE-1:0] out1_node3,
    input  logic                   out10_ready_node0,
    input  logic                   out10_ready_node1,
    input  logic                   out10_ready_node2,
    input  logic                   out10_ready_node3,
    input  logic                   out11_ready_node0,
    input  logic                   out11_ready_node1,
    input  logic                   out11_ready_node2,
    input  logic                   out11_ready_node3,
    output logic [OUTPUT_SIZE-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic [3:0]             out_idx,
    output logic                   busy,
    output logic                   overrun,
    input  logic                   overrun_clr
);

`ifdef GNN_ARGMAX_EN
    localparam int unsigned NWORDS = 9;
`else
    localparam int unsigned NWORDS = 8;
`endif
    localparam logic [3:0] LAST = 4'(NWORDS - 1);

    typedef enum logic {StIdle, StSend} state_t;

    state_t                 state_q, state_d;
    logic [3:0]             idx_q, idx_d;
    logic                   all_rdy, all_rdy_q;
    logic                   cap_evt, beat, final_beat, load, ovr_set;
    logic                   overrun_q, overrun_d;
    logic [OUTPUT_SIZE-1:0] in_word [8];
    logic [OUTPUT_SIZE-1:0] frame_buf_q [NWORDS];

    assign all_rdy = out10_ready_node0 & out10_ready_node1 & out10_ready_node2 &
                     out10_ready_node3 & out11_ready_node0 & out11_ready_node1 &
                     out11_ready_node2 & out11_ready_node3;
    assign cap_evt    = all_rdy & ~all_rdy_q;
    assign beat       = (state_q == StSend) & out_ready;
    assign final_beat = beat & (idx_q == LAST);

    always_comb begin
        in_word[0] = out0_node0;
        in_word[1] = out1_node0;
        in_word[2] = out0_node1;
        in_word[3] = out1_node1;
        in_word[4] = out0_node2;
        in_word[5] = out1_node2;
        in_word[6] = out0_node3;
        in_word[7] = out1_node3;
    end

`ifdef GNN_ARGMAX_EN
    logic [3:0] class_vec;
    always_comb begin
        class_vec[0] = $signed(out1_node0) > $signed(out0_node0);
        class_vec[1] = $signed(out1_node1) > $signed(out0_node1);
        class_vec[2] = $signed(out1_node2) > $signed(out0_node2);
        class_vec[3] = $signed(out1_node3) > $signed(out0_node3);
    end
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load    = 1'b0;
        ovr_set = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cap_evt) begin
                    load    = 1'b1;
                    idx_d   = 4'd0;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (final_beat) begin
                    // A capture coinciding with the final beat chains straight into the next frame.
                    idx_d   = 4'd0;
                    load    = cap_evt;
                    state_d = cap_evt ? StSend : StIdle;
                end else begin
                    if (beat) idx_d = idx_q + 4'd1;
                    ovr_set = cap_evt;
                end
            end
            default: state_d = StIdle;
        endcase
        overrun_d = ovr_set ? 1'b1 : (overrun_clr ? 1'b0 : overrun_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            idx_q     <= 4'd0;
            // Set so that flags still high out of reset are not mistaken for a new frame.
            all_rdy_q <= 1'b1;
            overrun_q <= 1'b0;
            for (int i = 0; i < NWORDS; i++) frame_buf_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            all_rdy_q <= all_rdy;
            overrun_q <= overrun_d;
            if (load) begin
                for (int i = 0; i < 8; i++) frame_buf_q[i] <= in_word[i];
`ifdef GNN_ARGMAX_EN
                frame_buf_q[8] <= {{(OUTPUT_SIZE-4){1'b0}}, class_vec};
`endif
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int i = 0; i < NWORDS; i++) begin
            if (idx_q == 4'(i)) out_data = frame_buf_q[i];
        end
    end

    assign out_valid = (state_q == StSend);
    assign busy      = out_valid;
    assign out_idx   = idx_q;
    assign out_last  = out_valid & (idx_q == LAST);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_gnn_result_collector.sv
// Directed self-checking bench for gnn_result_collector; define GNN_ARGMAX_EN to cover the
// class-vector word.
module tb_gnn_result_collector;

`ifdef GNN_ARGMAX_EN
    localparam int NW = 9;
`else
    localparam int NW = 8;
`endif
    localparam int W = 21;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] o0 [4];
    logic [W-1:0] o1 [4];
    logic         flags;
    logic [W-1:0] out_data;
    logic         out_valid, out_ready, out_last, busy, overrun, overrun_clr;
    logic [3:0]   out_idx;
    int           total = 0;
    int           bad = 0;

    always #5 clk = ~clk;

    gnn_result_collector #(.OUTPUT_SIZE(W)) dut (
        .clk(clk), .rst(rst),
        .out0_node0(o0[0]), .out0_node1(o0[1]), .out0_node2(o0[2]), .out0_node3(o0[3]),
        .out1_node0(o1[0]), .out1_node1(o1[1]), .out1_node2(o1[2]), .out1_node3(o1[3]),
        .out10_ready_node0(flags), .out10_ready_node1(flags),
        .out10_ready_node2(flags), .out10_ready_node3(flags),
        .out11_ready_node0(flags), .out11_ready_node1(flags),
        .out11_ready_node2(flags), .out11_ready_node3(flags),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .out_idx(out_idx), .busy(busy),
        .overrun(overrun), .overrun_clr(overrun_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int base);
        for (int k = 0; k < 4; k++) begin
            o0[k] = W'(base + 10 * k + 1);
            o1[k] = W'(base + 10 * k + 2);
        end
    endtask

    // out1 always exceeds out0 in set_data frames, so the class word is 4'b1111.
    function automatic logic [W-1:0] exp_word(input int base, input int i);
        if (i == 8) return W'(15);
        return W'(base + 10 * (i / 2) + 1 + (i % 2));
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++;
        if ({out_valid, out_last, busy, overrun} !== 4'b0 || out_data !== '0 || out_idx !== 4'd0) begin
            bad++;
            $display("FAIL reset: valid=%b last=%b busy=%b ovr=%b data=%0h idx=%0d, required all 0",
                     out_valid, out_last, busy, overrun, out_data, out_idx);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        set_data(0);
        flags = 1'b1;
        tick();
        for (int i = 0; i < NW; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== exp_word(0, i) || out_idx !== 4'(i) ||
                out_last !== (i == NW - 1)) begin
                bad++;
                $display("FAIL basic word %0d: valid=%b data=%0d idx=%0d last=%b, required 1 %0d %0d %b",
                         i, out_valid, out_data, out_idx, out_last, exp_word(0, i), i, i == NW - 1);
            end
            tick();
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL basic end busy: got %b, required 0", busy);
        end
        flags = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        int i = 0;
        int cyc = 0;
        set_data(100);
        flags = 1'b1;
        tick();
        while (i < NW && cyc < 100) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== exp_word(100, i) || out_idx !== 4'(i)) begin
                bad++;
                $display("FAIL backpressure cyc %0d: valid=%b data=%0d idx=%0d, required 1 %0d %0d",
                         cyc, out_valid, out_data, out_idx, exp_word(100, i), i);
            end
            out_ready = (cyc % 2 == 0);
            if (cyc == 1) flags = 1'b0;
            tick();
            if (out_ready) i++;
            cyc++;
        end
        total++;
        if (cyc != 2 * NW - 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL backpressure length: cycles=%0d busy=%b, required %0d 0",
                     cyc, busy, 2 * NW - 1);
        end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_overrun();
        set_data(200);
        flags = 1'b1;
        tick();
        for (int i = 0; i < NW; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== exp_word(200, i) || out_idx !== 4'(i)) begin
                bad++;
                $display("FAIL overrun frame word %0d: valid=%b data=%0d idx=%0d, required 1 %0d %0d",
                         i, out_valid, out_data, out_idx, exp_word(200, i), i);
            end
            if (i == 1) flags = 1'b0;
            if (i == 3) begin
                set_data(500);
                flags = 1'b1;
            end
            tick();
        end
        total++;
        if (overrun !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL overrun set: ovr=%b busy=%b, required 1 0", overrun, busy);
        end
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        total++;
        if (overrun !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL overrun clear: ovr=%b busy=%b, required 0 0", overrun, busy);
        end
        flags = 1'b0;
        tick();
    endtask

    task automatic test_coincident();
        set_data(300);
        flags = 1'b1;
        tick();
        for (int i = 0; i < NW; i++) begin
            if (i == 1) flags = 1'b0;
            if (i == NW - 1) begin
                set_data(400);
                flags = 1'b1;
            end
            tick();
        end
        total++;
        if (out_valid !== 1'b1 || out_idx !== 4'd0 || out_data !== exp_word(400, 0) ||
            overrun !== 1'b0) begin
            bad++;
            $display("FAIL coincident: valid=%b idx=%0d data=%0d ovr=%b, required 1 0 %0d 0",
                     out_valid, out_idx, out_data, overrun, exp_word(400, 0));
        end
        flags = 1'b0;
        for (int i = 0; i < NW; i++) begin
            total++;
            if (out_data !== exp_word(400, i) || out_idx !== 4'(i)) begin
                bad++;
                $display("FAIL coincident word %0d: data=%0d idx=%0d, required %0d %0d",
                         i, out_data, out_idx, exp_word(400, i), i);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        set_data(600);
        flags = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (out_idx !== 4'd4) begin
            bad++;
            $display("FAIL reset_mid pre idx: got %0d, required 4", out_idx);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({out_valid, out_last, busy, overrun} !== 4'b0 || out_data !== '0 || out_idx !== 4'd0) begin
            bad++;
            $display("FAIL reset_mid outputs: valid=%b last=%b busy=%b ovr=%b data=%0d idx=%0d, required 0",
                     out_valid, out_last, busy, overrun, out_data, out_idx);
        end
        for (int i = 0; i < 3; i++) tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid held flags: busy=%b, required 0", busy);
        end
        flags = 1'b0;
        tick();
        flags = 1'b1;
        tick();
        total++;
        if (out_valid !== 1'b1 || out_data !== exp_word(600, 0)) begin
            bad++;
            $display("FAIL reset_mid recapture: valid=%b data=%0d, required 1 %0d",
                     out_valid, out_data, exp_word(600, 0));
        end
        flags = 1'b0;
        for (int i = 0; i < NW; i++) tick();
    endtask

`ifdef GNN_ARGMAX_EN
    task automatic test_argmax();
        logic [W-1:0] exp [9];
        o0[0] = W'(5);  o1[0] = W'(9);
        o0[1] = W'(-3); o1[1] = W'(-7);
        o0[2] = W'(4);  o1[2] = W'(4);
        o0[3] = W'(-1); o1[3] = W'(0);
        exp[0] = W'(5);  exp[1] = W'(9);  exp[2] = W'(-3); exp[3] = W'(-7);
        exp[4] = W'(4);  exp[5] = W'(4);  exp[6] = W'(-1); exp[7] = W'(0);
        exp[8] = W'(9);
        flags = 1'b1;
        tick();
        flags = 1'b0;
        for (int i = 0; i < 9; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== exp[i] || out_last !== (i == 8)) begin
                bad++;
                $display("FAIL argmax word %0d: valid=%b data=%0h last=%b, required 1 %0h %b",
                         i, out_valid, out_data, out_last, exp[i], i == 8);
            end
            tick();
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL argmax end busy: got %b, required 0", busy);
        end
    endtask
`endif

    initial begin
        rst         = 1'b1;
        flags       = 1'b0;
        out_ready   = 1'b1;
        overrun_clr = 1'b0;
        set_data(0);
        test_reset();
        test_basic();
        test_backpressure();
        test_overrun();
        test_coincident();
        test_reset_mid();
`ifdef GNN_ARGMAX_EN
        test_argmax();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
